dcache_queue: RTL
=================

# dcache_queue

Parametrised, multi-entry successor to the single-slot data-memory port between the store/load buffer (SLB) and the memory controller. Accepts up to DEPTH load/store requests from the SLB and issues them to the memory controller strictly in order, one at a time. Returns size-extended load data tagged with the request nick. On a pipeline clear, pending loads are discarded and already-accepted stores are kept and still written.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- NICK_W, 5: nick (ROB tag) width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds and no handshakes complete.
- clr  in  1  pipeline clear (misprediction), synchronous.
- iSLB_en  in  1  request valid.
- oSLB_en  out  1  ready; high when count < DEPTH, rst/clr low, rdy high.
- iSLB_ls  in  1  1 = store, 0 = load.
- iSLB_pc  in  ADDR_W  byte address.
- iSLB_dt  in  DATA_W  store data, low bytes used.
- iSLB_len  in  3  byte count: 1, 2 or 4.
- iSLB_sext  in  1  load sign-extend (LB/LH = 1, LBU/LHU/LW = 0).
- iSLB_nick  in  NICK_W  tag.
- oSLB_done  out  1  one-cycle completion pulse.
- oSLB_dt  out  DATA_W  extended load data; 0 for stores.
- oSLB_nick  out  NICK_W  tag of the completed entry.
- oMC_en, oMC_ls, oMC_pc, oMC_dt, oMC_len  out  1/1/ADDR_W/DATA_W/3  request to the memory controller.
- iMC_done  in  1  one-cycle pulse; the current transaction is finished.
- iMC_dt  in  DATA_W  load data, valid with iMC_done.

## Operation
- Circular FIFO with head/tail pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Each entry stores ls, pc, dt, len, sext, nick, plus two flags:
  - live: perform the memory access.
  - report: pulse done on completion.
- Accept: iSLB_en && oSLB_en && rdy && !clr writes the tail entry with live=1 and report=1, then tail++.
- Issue: oMC_* is registered from the head entry. oMC_en=1 while the head is live and not yet done.
- Pop:
  - A live head pops on iMC_done.
  - A non-live head pops in one cycle with no MC request and no done pulse.
- Completion: on iMC_done with head.report=1, the next cycle gives oSLB_done=1 and oSLB_nick=head.nick.
- Load data extension:
  - len=1: {24×(sext&b7), b[7:0]}.
  - len=2: {16×(sext&b15), b[15:0]}.
  - len=4: the full word.
  - Stores: oSLB_dt=0.
- clr, per entry:
  - Every entry gets report=0.
  - Load entries not in flight get live=0.
  - An in-flight head load stays live until iMC_done, because the memctrl transaction is never aborted; it then pops silently.
  - Stores stay live and complete silently.
- Simultaneous accept and pop in the same cycle: count is unchanged. A full queue that pops this cycle still deasserts oSLB_en this cycle; readiness is based on the registered count.
- clr together with iSLB_en: the incoming request is dropped.
- Reset output values: oSLB_done=0, oSLB_dt=0, oSLB_nick=0, oMC_en=0, oMC_ls=0, oMC_pc=0, oMC_dt=0, oMC_len=0. Pointers and count are 0 and all flags are 0. oSLB_en is 1 after reset deasserts.
- Reset mid-transaction: the queue empties and oMC_en=0 on the next edge. The memory controller is reset by the same rst.

## Timing
- Accept at edge N → oMC_en=1 from cycle N+1 when the queue was empty.
- iMC_done at cycle M → oSLB_done at M+1. The next entry's oMC_en is visible at M+1, so back-to-back issue has one idle cycle at most.
- A non-live head is discarded in 1 cycle per entry.
- Queue latency for a request = (entries ahead) × MC latency + 1.
- rdy low freezes everything, including the oSLB_done register.

## Configuration
- DCACHE_Q_BYPASS_EN defined:
  - When the queue is empty, no transaction is in flight, and clr=0, an accepted request drives oMC_* combinationally from iSLB_* in the accept cycle.
  - The entry is still written and marked issued.
  - Load-to-MC latency is 0 cycles.
- Undefined: oMC_* is purely registered, with a 1-cycle issue latency as in Timing.

## Test plan
- Single load: LB at pc=0x100, nick=3, sext=1, MC returns 0x000000F0 after 3 cycles → oSLB_done 1 cycle later, oSLB_dt=0xFFFFFFF0, oSLB_nick=3.
- Fill: 4 back-to-back stores with MC stalled → oSLB_en=0 after the 4th. Stores are issued in order with pc 0x0, 0x4, 0x8, 0xC. There are 4 done pulses with oSLB_dt=0.
- Wrap: 10 alternating LHU/LW requests, MC latency 1 → pointers wrap twice. Nicks come back in order. LHU of 0x1234ABCD returns 0x0000ABCD.
- clr: queue = [load A in flight, store B, load C]; clr asserted → A completes silently. B is still written to MC with no done pulse. C is never issued. count=0 within 3 cycles after A's iMC_done.
- Simultaneous: queue full, iMC_done and iSLB_en in the same cycle → new entry accepted the next cycle, count stays 4, no loss or duplication.
- rst asserted while a load is in flight → all outputs at reset values on the next edge. A new request after reset gets a fresh nick and completes normally.

Source files
------------

// File: rtl/dcache_queue.sv
// In-order load/store request queue between the SLB and the memory controller.
// Define DCACHE_Q_BYPASS_EN to drive an empty-queue request straight to the MC in its accept cycle.
module dcache_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NICK_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iSLB_en,
  output logic              oSLB_en,
  input  logic              iSLB_ls,
  input  logic [ADDR_W-1:0] iSLB_pc,
  input  logic [DATA_W-1:0] iSLB_dt,
  input  logic [2:0]        iSLB_len,
  input  logic              iSLB_sext,
  input  logic [NICK_W-1:0] iSLB_nick,
  output logic              oSLB_done,
  output logic [DATA_W-1:0] oSLB_dt,
  output logic [NICK_W-1:0] oSLB_nick,
  output logic              oMC_en,
  output logic              oMC_ls,
  output logic [ADDR_W-1:0] oMC_pc,
  output logic [DATA_W-1:0] oMC_dt,
  output logic [2:0]        oMC_len,
  input  logic              iMC_done,
  input  logic [DATA_W-1:0] iMC_dt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              e_ls     [DEPTH];
  logic [ADDR_W-1:0] e_pc     [DEPTH];
  logic [DATA_W-1:0] e_dt     [DEPTH];
  logic [2:0]        e_len    [DEPTH];
  logic              e_sext   [DEPTH];
  logic [NICK_W-1:0] e_nick   [DEPTH];
  logic              e_live   [DEPTH];
  logic              e_report [DEPTH];

  logic [PTR_W-1:0]  head, tail, head_n, tail_n;
  logic [CNT_W-1:0]  count, count_n;

  logic              mc_en_q, mc_ls_q;
  logic [ADDR_W-1:0] mc_pc_q;
  logic [DATA_W-1:0] mc_dt_q;
  logic [2:0]        mc_len_q;
  logic              done_q;
  logic [DATA_W-1:0] done_dt_q;
  logic [NICK_W-1:0] done_nick_q;

  logic              acc, bypass, mc_active, pop_live, pop_dead, pop;
  logic              h_ls, h_sext, h_report;
  logic [2:0]        h_len;
  logic [NICK_W-1:0] h_nick;
  logic              new_is_head, live_n, mc_en_n;
  logic              n_ls;
  logic [ADDR_W-1:0] n_pc;
  logic [DATA_W-1:0] n_dt;
  logic [2:0]        n_len;
  logic              report_fire;
  logic [DATA_W-1:0] done_dt;

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] len, input logic sext,
                                               input logic [DATA_W-1:0] d);
    case (len)
      3'd1:    extend = {{(DATA_W-8){sext & d[7]}}, d[7:0]};
      3'd2:    extend = {{(DATA_W-16){sext & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign oSLB_en = (count < CNT_W'(DEPTH)) && !rst && !clr && rdy;
  assign acc     = iSLB_en && oSLB_en;

`ifdef DCACHE_Q_BYPASS_EN
  assign bypass  = acc && (count == '0) && !mc_en_q;
  assign oMC_en  = bypass ? 1'b1      : mc_en_q;
  assign oMC_ls  = bypass ? iSLB_ls   : mc_ls_q;
  assign oMC_pc  = bypass ? iSLB_pc   : mc_pc_q;
  assign oMC_dt  = bypass ? iSLB_dt   : mc_dt_q;
  assign oMC_len = bypass ? iSLB_len  : mc_len_q;
`else
  assign bypass  = 1'b0;
  assign oMC_en  = mc_en_q;
  assign oMC_ls  = mc_ls_q;
  assign oMC_pc  = mc_pc_q;
  assign oMC_dt  = mc_dt_q;
  assign oMC_len = mc_len_q;
`endif

  // Head view: a bypassed request acts as the head before it lands in the array.
  assign h_ls     = bypass ? iSLB_ls   : e_ls[head];
  assign h_len    = bypass ? iSLB_len  : e_len[head];
  assign h_sext   = bypass ? iSLB_sext : e_sext[head];
  assign h_nick   = bypass ? iSLB_nick : e_nick[head];
  assign h_report = bypass ? 1'b1      : e_report[head];

  assign mc_active = mc_en_q || bypass;
  assign pop_live  = mc_active && iMC_done;
  assign pop_dead  = (count != '0) && !e_live[head] && !mc_en_q;
  assign pop       = pop_live || pop_dead;

  assign head_n  = head + PTR_W'(pop);
  assign tail_n  = tail + PTR_W'(acc);
  assign count_n = count + CNT_W'(acc) - CNT_W'(pop);

  // Next head is the incoming request only when nothing older remains.
  assign new_is_head = acc && (count_n != '0) && (head_n == tail);
  assign live_n  = new_is_head ? 1'b1 :
                   pop         ? (e_live[head_n] && !(clr && !e_ls[head_n])) :
                                 e_live[head];
  assign mc_en_n = (count_n != '0) && live_n;
  assign n_ls    = new_is_head ? iSLB_ls  : e_ls[head_n];
  assign n_pc    = new_is_head ? iSLB_pc  : e_pc[head_n];
  assign n_dt    = new_is_head ? iSLB_dt  : e_dt[head_n];
  assign n_len   = new_is_head ? iSLB_len : e_len[head_n];

  assign report_fire = pop_live && h_report && !clr;
  assign done_dt     = h_ls ? '0 : extend(h_len, h_sext, iMC_dt);

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      mc_en_q     <= 1'b0;
      mc_ls_q     <= 1'b0;
      mc_pc_q     <= '0;
      mc_dt_q     <= '0;
      mc_len_q    <= '0;
      done_q      <= 1'b0;
      done_dt_q   <= '0;
      done_nick_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_live[PTR_W'(i)]   <= 1'b0;
        e_report[PTR_W'(i)] <= 1'b0;
      end
    end else if (rdy) begin
      if (acc) begin
        e_ls[tail]     <= iSLB_ls;
        e_pc[tail]     <= iSLB_pc;
        e_dt[tail]     <= iSLB_dt;
        e_len[tail]    <= iSLB_len;
        e_sext[tail]   <= iSLB_sext;
        e_nick[tail]   <= iSLB_nick;
        e_live[tail]   <= 1'b1;
        e_report[tail] <= 1'b1;
      end
      // Clear silences everything; only the in-flight load and stores keep their access.
      if (clr) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          e_report[PTR_W'(i)] <= 1'b0;
          if (!e_ls[PTR_W'(i)] && !((PTR_W'(i) == head) && mc_en_q))
            e_live[PTR_W'(i)] <= 1'b0;
        end
      end
      head     <= head_n;
      tail     <= tail_n;
      count    <= count_n;
      mc_en_q  <= mc_en_n;
      mc_ls_q  <= mc_en_n ? n_ls  : 1'b0;
      mc_pc_q  <= mc_en_n ? n_pc  : '0;
      mc_dt_q  <= mc_en_n ? n_dt  : '0;
      mc_len_q <= mc_en_n ? n_len : '0;
      done_q   <= report_fire;
      if (report_fire) begin
        done_dt_q   <= done_dt;
        done_nick_q <= h_nick;
      end
    end
  end

  assign oSLB_done = done_q;
  assign oSLB_dt   = done_dt_q;
  assign oSLB_nick = done_nick_q;

endmodule
